ex_mdu: RTL and testbench

Multiply/divide unit for the EX stage, directly upstream of the EX/MEM pipeline register. It executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency and owns the HI/LO architectural registers. It serves MTHI/MTLO writes and MFHI/MFLO reads. It exports `busy` so hazard logic can stall MDU-class instructions in decode, and it accepts the exception request so that a flushed instruction never alters HI/LO.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_calc.sv | 55 +++++
 rtl/ex_mdu.sv | 101 ++++++++++
 tb/tb_ex_mdu.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// default latencies and the packed {hi, lo} result type.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE = 4'd0;
  localparam logic [3:0] MULT     = 4'd1;
  localparam logic [3:0] MULTU    = 4'd2;
  localparam logic [3:0] DIV      = 4'd3;
  localparam logic [3:0] DIVU     = 4'd4;
  localparam logic [3:0] MFHI     = 4'd5;
  localparam logic [3:0] MFLO     = 4'd6;
  localparam logic [3:0] MTHI     = 4'd7;
  localparam logic [3:0] MTLO     = 4'd8;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_result_t;

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: product or quotient/remainder for the EX operands,
// plus a divide-by-zero flag so the shell can drop the write-back.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output mdu_result_t res_o,
  output logic        div_zero_o
);

  logic        is_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign is_signed = (op_i == MULT) || (op_i == DIV);

  // Sign-extending to 64 bits makes one unsigned multiplier serve both forms.
  assign a_ext = {{32{is_signed & a_i[31]}}, a_i};
  assign b_ext = {{32{is_signed & b_i[31]}}, b_i};
  assign prod  = a_ext * b_ext;

  // Divide on magnitudes so 0x80000000 / -1 never overflows a signed divider.
  assign a_neg = is_signed & a_i[31];
  assign b_neg = is_signed & b_i[31];
  assign a_mag = a_neg ? (~a_i + 32'd1) : a_i;
  assign b_mag = (b_i == 32'd0) ? 32'd1 : (b_neg ? (~b_i + 32'd1) : b_i);
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

  assign div_zero_o = ((op_i == DIV) || (op_i == DIVU)) && (b_i == 32'd0);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    res_o = '0;
    case (op_i)
      MULT, MULTU: res_o = prod;
      DIV, DIVU:   res_o = '{hi: rem, lo: quot};
      default:     res_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide shell: fixed-latency issue, HI/LO ownership,
// MTxx/MFxx service and flush suppression through req.
module ex_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  mdu_result_t      p_q, p_d;
  logic             p_wr_q, p_wr_d;

  mdu_result_t      calc_res;
  logic             calc_div_zero;
  logic             is_arith;
  logic             is_div;

  mdu_calc u_calc (
    .op_i       (op),
    .a_i        (A),
    .b_i        (B),
    .res_o      (calc_res),
    .div_zero_o (calc_div_zero)
  );

  assign is_arith = (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  assign is_div   = (op == DIV) || (op == DIVU);
  assign busy     = (cnt_q != '0);
  assign start    = is_arith && !req && !busy;

  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    p_d    = p_q;
    p_wr_d = p_wr_q;
    if (start) begin
      // Result is parked in the pending registers; HI/LO change only on completion.
      p_d    = calc_res;
      p_wr_d = !calc_div_zero;
      cnt_d  = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (busy) begin
      cnt_d = cnt_q - 1'b1;
      if ((cnt_q == CNT_W'(1)) && p_wr_q) begin
        hi_d = p_q.hi;
        lo_d = p_q.lo;
      end
    end else if (!req) begin
      if (op == MTHI) hi_d = A;
      if (op == MTLO) lo_d = A;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      p_q    <= '0;
      p_wr_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      p_q    <= p_d;
      p_wr_q <= p_wr_d;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (op)
      MFHI:    rd_data = hi_q;
      MFLO:    rd_data = lo_q;
      default: rd_data = 32'd0;
    endcase
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: latency, MULT/DIV results, div-by-zero,
// req suppression, reset abort, MTxx/MFxx and start-while-busy.
module tb_ex_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] rd_data;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_pass   = 0;

  ex_mdu #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .op      (op),
    .A       (A),
    .B       (B),
    .start   (start),
    .busy    (busy),
    .rd_data (rd_data),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one edge, checking the combinational start beforehand.
  task automatic issue(input string tag, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic exp_start);
    op = o; A = a; B = b;
    #1;
    check({tag, ".start"}, 32'(start), 32'(exp_start));
    tick();
    op = MDU_NONE; A = '0; B = '0;
  endtask

  // Count cycles with busy high (bounded), then compare against the latency.
  task automatic wait_done(input string tag, input int already, input int lat);
    int n = already;
    while (busy && n < 64) begin
      n++;
      tick();
    end
    check({tag, ".lat"}, 32'(n), 32'(lat));
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(tag, o, a, b, 1'b1);
    wait_done(tag, 0, lat);
    check({tag, ".hi"}, HI, exp_hi);
    check({tag, ".lo"}, LO, exp_lo);
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; op = MDU_NONE; A = '0; B = '0;
    #2;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.hi", HI, 32'd0);
    check("rst.lo", LO, 32'd0);
    check("rst.start", 32'(start), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    run_op("mult",  MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div",   DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  DIVU,  32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("divovf", DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_op("b2b",   MULTU, 32'h0001_0000, 32'h0001_0000, 5, 32'd1, 32'd0);

    // Divide by zero keeps preloaded HI/LO.
    issue("mthi", MTHI, 32'h11, 32'd0, 1'b0);
    issue("mtlo", MTLO, 32'h22, 32'd0, 1'b0);
    op = MFHI; #1;
    check("mfhi.rd", rd_data, 32'h11);
    run_op("div0", DIV, 32'd99, 32'd0, 10, 32'h11, 32'h22);

    // Flush in the accept cycle suppresses the MULT completely.
    req = 1'b1;
    issue("reqacc", MULT, 32'd5, 32'd7, 1'b0);
    req = 1'b0;
    check("reqacc.busy", 32'(busy), 32'd0);
    check("reqacc.hi", HI, 32'h11);
    check("reqacc.lo", LO, 32'h22);

    // In-flight MULT survives req and ignores a second MULT while busy.
    issue("fly", MULT, 32'd5, 32'd7, 1'b1);
    issue("fly2", MULT, 32'd2, 32'd2, 1'b0);
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_done("fly", 2, 5);
    check("fly.hi", HI, 32'd0);
    check("fly.lo", LO, 32'd35);

    // MTLO then MFLO next cycle.
    issue("mtlo2", MTLO, 32'h1234, 32'd0, 1'b0);
    op = MFLO; #1;
    check("mflo.rd", rd_data, 32'h1234);
    op = MTHI; A = 32'hDEAD; req = 1'b1;
    tick();
    req = 1'b0;
    op = MFHI; #1;
    check("mthi_req.rd", rd_data, 32'd0);
    op = MDU_NONE; #1;
    check("none.rd", rd_data, 32'd0);

    // Reset in cycle 3 of a DIV aborts it for good.
    issue("rstdiv", DIV, 32'd100, 32'd7, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rstdiv.busy", 32'(busy), 32'd0);
    check("rstdiv.hi", HI, 32'd0);
    check("rstdiv.lo", LO, 32'd0);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("rstdiv.busy_late", 32'(busy), 32'd0);
    check("rstdiv.hi_late", HI, 32'd0);
    check("rstdiv.lo_late", LO, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
